// File: rtl/rv_muldiv_unit.sv
// RISC-V M-extension multiply/divide unit: shift-add multiply, restoring divide, RV64 W-ops.
// Optional last-result cache is enabled by defining MULDIV_RESULT_CACHE_EN.
module rv_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [2:0]      FUNCT3,
  input  logic            WORD_OP,
  input  logic [XLEN-1:0] RS1,
  input  logic [XLEN-1:0] RS2,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_SPECIAL, S_DONE} state_t;
  state_t state_q, state_d;

  logic [2:0]        f3_q;
  logic              word_q, neg_q, a_neg_q;
  logic [CW-1:0]     cnt_q, last_q;
  logic [2*XLEN-1:0] work_q;
  logic [XLEN-1:0]   oper_q, result_q;

  logic              accept, load_res, cache_hit;
  logic [XLEN-1:0]   res_d, cache_res;

  function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
    return XLEN'(v) | ({XLEN{v[31]}} & ~XLEN'(32'hFFFF_FFFF));
  endfunction

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? sx32(v[31:0]) : v;
  endfunction

  // Request decode: operand extension, magnitudes and special-case detection.
  logic            word_in, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_raw, b_raw, a_mag, b_mag, spec_res;

  always_comb begin
    word_in  = (XLEN == 64) && WORD_OP && ((FUNCT3 == 3'd0) || FUNCT3[2]);
    a_sgn    = (FUNCT3 == 3'd1) || (FUNCT3 == 3'd2) || (FUNCT3 == 3'd4) || (FUNCT3 == 3'd6);
    b_sgn    = (FUNCT3 == 3'd1) || (FUNCT3 == 3'd4) || (FUNCT3 == 3'd6);
    a_raw    = word_in ? (a_sgn ? sx32(RS1[31:0]) : XLEN'(RS1[31:0])) : RS1;
    b_raw    = word_in ? (b_sgn ? sx32(RS2[31:0]) : XLEN'(RS2[31:0])) : RS2;
    a_neg    = a_sgn & a_raw[XLEN-1];
    b_neg    = b_sgn & b_raw[XLEN-1];
    a_mag    = a_neg ? -a_raw : a_raw;
    b_mag    = b_neg ? -b_raw : b_raw;
    div_zero = (b_raw == '0);
    div_ovf  = FUNCT3[2] & ~FUNCT3[0] & (&b_raw) &
               (a_raw == (word_in ? sx32(32'h8000_0000) : XMIN));
    spec_res = FUNCT3[1] ? (div_zero ? a_raw : '0) : (div_zero ? '1 : a_raw);
  end

  // Iteration datapath; work_q holds {hi, lo} product or {remainder, dividend/quotient}.
  logic [XLEN+MUL_BITS-1:0] pp, hi_sum;
  logic [2*XLEN-1:0]        mul_nxt, div_nxt;
  logic [XLEN:0]            div_sh, div_diff;
  logic [XLEN-1:0]          mul_res, fix_res, quo, rem;

  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_BITS; i++)
      if (work_q[i]) pp = pp + ((XLEN+MUL_BITS)'(oper_q) << i);
    hi_sum  = (XLEN+MUL_BITS)'(work_q[2*XLEN-1:XLEN]) + pp;
    mul_nxt = {hi_sum, work_q[XLEN-1:MUL_BITS]};

    div_sh   = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    div_diff = div_sh - {1'b0, oper_q};
    div_nxt  = {div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0],
                work_q[XLEN-2:0], ~div_diff[XLEN]};

    // A W-mul retires only 32 bits, leaving the product XLEN/2 bits up.
    if (f3_q == 3'd0)
      mul_res = word_q ? sx32(mul_nxt[XLEN/2 +: 32]) : mul_nxt[XLEN-1:0];
    else if (neg_q)
      mul_res = ~mul_nxt[2*XLEN-1:XLEN] + XLEN'(mul_nxt[XLEN-1:0] == '0);
    else
      mul_res = mul_nxt[2*XLEN-1:XLEN];

    quo     = neg_q   ? -work_q[XLEN-1:0]      : work_q[XLEN-1:0];
    rem     = a_neg_q ? -work_q[2*XLEN-1:XLEN] : work_q[2*XLEN-1:XLEN];
    fix_res = wfix(word_q, f3_q[1] ? rem : quo);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    load_res = 1'b0;
    res_d    = result_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID && !FLUSH) begin
          accept = 1'b1;
          if (cache_hit) begin
            state_d  = S_DONE;
            load_res = 1'b1;
            res_d    = cache_res;
          end else if (FUNCT3[2]) begin
            state_d = (div_zero || div_ovf) ? S_SPECIAL : S_DIV;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL: if (cnt_q == last_q) begin
        state_d  = S_DONE;
        load_res = 1'b1;
        res_d    = mul_res;
      end
      S_DIV: if (cnt_q == last_q) state_d = S_FIX;
      S_FIX: begin
        state_d  = S_DONE;
        load_res = 1'b1;
        res_d    = fix_res;
      end
      S_SPECIAL: begin
        state_d  = S_DONE;
        load_res = 1'b1;
        res_d    = wfix(word_q, work_q[XLEN-1:0]);
      end
      S_DONE:  if (OUT_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (FLUSH) begin
      state_d  = S_IDLE;
      load_res = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      f3_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      cnt_q    <= '0;
      last_q   <= '0;
      work_q   <= '0;
      oper_q   <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        f3_q    <= FUNCT3;
        word_q  <= word_in;
        neg_q   <= a_neg ^ b_neg;
        a_neg_q <= a_neg;
        cnt_q   <= '0;
        if (FUNCT3[2]) begin
          // W-divide parks the 32-bit dividend in the top half so 32 steps suffice.
          last_q <= word_in ? CW'(31) : CW'(XLEN - 1);
          work_q <= {{XLEN{1'b0}}, (div_zero | div_ovf) ? spec_res :
                                   (word_in ? (a_mag << (XLEN/2)) : a_mag)};
          oper_q <= b_mag;
        end else begin
          last_q <= word_in ? CW'(32/MUL_BITS - 1) : CW'(XLEN/MUL_BITS - 1);
          work_q <= {{XLEN{1'b0}}, b_mag};
          oper_q <= a_mag;
        end
      end else if (state_q == S_MUL) begin
        work_q <= mul_nxt;
        cnt_q  <= cnt_q + CW'(1);
      end else if (state_q == S_DIV) begin
        work_q <= div_nxt;
        cnt_q  <= cnt_q + CW'(1);
      end
      if (load_res) result_q <= res_d;
    end
  end

`ifdef MULDIV_RESULT_CACHE_EN
  logic            c_vld, c_word, op_word_q;
  logic [2:0]      c_f3;
  logic [XLEN-1:0] c_rs1, c_rs2, c_res, op_rs1_q, op_rs2_q;

  assign cache_hit = c_vld && (c_f3 == FUNCT3) && (c_word == WORD_OP) &&
                     (c_rs1 == RS1) && (c_rs2 == RS2);
  assign cache_res = c_res;

  // Only a delivered result is remembered; flushed or reset ops never reach the handshake.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      c_vld     <= 1'b0;
      c_word    <= 1'b0;
      c_f3      <= '0;
      c_rs1     <= '0;
      c_rs2     <= '0;
      c_res     <= '0;
      op_word_q <= 1'b0;
      op_rs1_q  <= '0;
      op_rs2_q  <= '0;
    end else begin
      if (accept) begin
        op_word_q <= WORD_OP;
        op_rs1_q  <= RS1;
        op_rs2_q  <= RS2;
      end
      if (state_q == S_DONE && OUT_READY && !FLUSH) begin
        c_vld  <= 1'b1;
        c_f3   <= f3_q;
        c_word <= op_word_q;
        c_rs1  <= op_rs1_q;
        c_rs2  <= op_rs2_q;
        c_res  <= result_q;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  assign IN_READY  = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign RESULT    = result_q;

endmodule

// File: doc/rv_muldiv_unit.md
RV_MULDIV_UNIT -- requirements
Module: rv_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (32 or 64).
REQ-002 SHALL have parameter MUL_BITS, default 4, multiplier bits retired per cycle; must divide XLEN.
REQ-003 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port IN_VALID  input  1  request present.
REQ-006 SHALL have port IN_READY  output  1  unit can accept; high only in IDLE.
REQ-007 SHALL have port FUNCT3  input  3  RV M-op: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
REQ-008 SHALL have port WORD_OP  input  1  RV64 W-variant select; ignored when XLEN=32.
REQ-009 SHALL have port RS1  input  XLEN  dividend/multiplicand.
REQ-010 SHALL have port RS2  input  XLEN  divisor/multiplier.
REQ-011 SHALL have port FLUSH  input  1  abort in-flight op.
REQ-012 SHALL have port OUT_VALID  output  1  RESULT valid.
REQ-013 SHALL have port OUT_READY  input  1  consumer accepts RESULT.
REQ-014 SHALL have port RESULT  output  XLEN  registered result.
REQ-015 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL accept a request when IN_VALID & IN_READY; FUNCT3, WORD_OP, RS1, RS2 latched that edge.
REQ-017 SHALL implement FSM IDLE -> MUL|DIV|SPECIAL -> (DIV -> FIX) -> DONE -> IDLE.
REQ-018 MUL SHALL be shift-add, MUL_BITS bits per cycle, XLEN/MUL_BITS cycles, 2*XLEN product; signedness per RISC-V (mulh s*s, mulhsu s*u, mulhu u*u); mul returns low XLEN, others high XLEN.
REQ-019 DIV SHALL be restoring radix-2 on magnitudes, XLEN cycles, then one FIX cycle applying signs (quotient negated if signs differ; remainder takes dividend sign).
REQ-020 Divide by zero SHALL go to SPECIAL (1 cycle): quotient all ones, remainder = RS1.
REQ-021 Signed overflow (most-negative / -1) SHALL go to SPECIAL: quotient = RS1, remainder 0.
REQ-022 WORD_OP with XLEN=64 SHALL use RS1[31:0], RS2[31:0] (sign- or zero-extended per op), iterate 32 cycles, and sign-extend bit 31 of the 32-bit result; WORD_OP with FUNCT3 1-3 SHALL be treated as non-word.
REQ-023 Latency accept-edge to OUT_VALID: MUL XLEN/MUL_BITS+1 cycles; DIV XLEN+2 (34 for W); SPECIAL 2.
REQ-024 DONE SHALL hold OUT_VALID and RESULT stable until OUT_READY; handshake edge returns to IDLE; IN_READY SHALL NOT be high the same cycle (no back-to-back overlap).
REQ-025 FLUSH SHALL return FSM to IDLE next edge from any state, drop OUT_VALID, produce no result; FLUSH with IN_VALID in IDLE SHALL reject the request.
REQ-026 RESULT SHALL change only on entry to DONE.

Reset
REQ-027 On RST_N low at a rising edge: FSM IDLE, OUT_VALID 0, BUSY 0, RESULT 0, IN_READY 1 after release; reset mid-operation SHALL discard the op.
REQ-028 Reset SHALL take priority over FLUSH and handshakes.

Configuration
REQ-029 Macro MULDIV_RESULT_CACHE_EN defined: unit SHALL store FUNCT3, WORD_OP, RS1, RS2, RESULT of last completed op; accepted request matching all four SHALL go directly to DONE, OUT_VALID next cycle; cache invalidated by reset only; flushed ops SHALL NOT update it.
REQ-030 Macro undefined: no cache storage; every op takes full latency of REQ-023.

Verification
REQ-031 XLEN=32: mul 0x00000007 x 0xFFFFFFFD -> RESULT 0xFFFFFFEB, OUT_VALID 9 cycles after accept.
REQ-032 mulh 0x80000000 x 0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-033 div -7/2 -> 0xFFFFFFFD, rem -7/2 -> 0xFFFFFFFF, 34 cycles; divu 5/0 -> 0xFFFFFFFF, rem 5/0 -> 5, div 0x80000000/-1 -> 0x80000000, each in 2 cycles.
REQ-034 OUT_READY held low 5 cycles in DONE -> RESULT/OUT_VALID stable, IN_READY 0; FLUSH at cycle 10 of a div -> IDLE next edge, no OUT_VALID.
REQ-035 XLEN=64 divw 0x00000000_FFFFFFF9 / 2 -> 0xFFFFFFFF_FFFFFFFD; RST_N low mid-div -> IDLE, OUT_VALID 0.
REQ-036 With MULDIV_RESULT_CACHE_EN: repeat identical div -> OUT_VALID 1 cycle after accept, same RESULT; without macro -> 34 cycles.
